// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses pll_rst, waits for stable lock, then releases sys_reset.
// Define PLL_LOCK_TIMEOUT_EN to enable the WAIT_LOCK timeout and retry_cnt.
module pll_reset_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1000000,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart_req,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [3:0] retry_cnt,
    output logic       lock_lost
);

    localparam int MAX_RS = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
`ifdef PLL_LOCK_TIMEOUT_EN
    localparam int MAXP = (MAX_RS > LOCK_TIMEOUT) ? MAX_RS : LOCK_TIMEOUT;
`else
    localparam int MAXP = MAX_RS;
`endif
    localparam int CW = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] RST_LD = CW'(RST_CYCLES);
    localparam logic [CW-1:0] SET_LD = CW'(SETTLE_CYCLES);
`ifdef PLL_LOCK_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LD  = CW'(LOCK_TIMEOUT);
`endif
    localparam logic [CW-1:0] ONE    = CW'(1);

    if (RST_CYCLES < 1) begin : g_chk_rst
        $error("RST_CYCLES must be at least 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_chk_settle
        $error("SETTLE_CYCLES must be at least 1");
    end
    if (LOCK_TIMEOUT < 1) begin : g_chk_timeout
        $error("LOCK_TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_SETTLE,
        S_RUN
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    sync;
    logic          lock_s;
    logic          lost;
    logic          cnt_last;
`ifdef PLL_LOCK_TIMEOUT_EN
    logic          timeout;
`endif

    assign lock_s   = sync[1];
    assign cnt_last = (cnt == ONE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lost    = 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
        timeout = 1'b0;
`endif
        // restart wins over lock loss and timeout
        if (restart_req) begin
            state_n = S_PLL_RST;
            cnt_n   = RST_LD;
        end else begin
            unique case (state)
                S_PLL_RST: begin
                    if (cnt_last) begin
                        state_n = S_WAIT_LOCK;
`ifdef PLL_LOCK_TIMEOUT_EN
                        cnt_n   = TO_LD;
`endif
                    end else begin
                        cnt_n = cnt - ONE;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_n = S_SETTLE;
                        cnt_n   = SET_LD;
                    end
`ifdef PLL_LOCK_TIMEOUT_EN
                    else if (cnt_last) begin
                        state_n = S_PLL_RST;
                        cnt_n   = RST_LD;
                        timeout = 1'b1;
                    end else begin
                        cnt_n = cnt - ONE;
                    end
`endif
                end
                S_SETTLE: begin
                    if (!lock_s) begin
                        state_n = S_WAIT_LOCK;
`ifdef PLL_LOCK_TIMEOUT_EN
                        cnt_n   = TO_LD;
`endif
                    end else if (cnt_last) begin
                        state_n = S_RUN;
                    end else begin
                        cnt_n = cnt - ONE;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_n = S_PLL_RST;
                        cnt_n   = RST_LD;
                        lost    = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync      <= 2'b00;
            state     <= S_PLL_RST;
            cnt       <= RST_LD;
            pll_rst   <= 1'b1;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            sync      <= {sync[0], pll_locked};
            state     <= state_n;
            cnt       <= cnt_n;
            pll_rst   <= (state_n == S_PLL_RST);
            sys_reset <= (state_n != S_RUN);
            ready     <= (state_n == S_RUN);
            if (lost) begin
                lock_lost <= 1'b1;
            end
        end
    end

`ifdef PLL_LOCK_TIMEOUT_EN
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            retry_cnt <= 4'd0;
        end else if (timeout && (retry_cnt != 4'hF)) begin
            retry_cnt <= retry_cnt + 4'd1;
        end
    end
`else
    assign retry_cnt = 4'd0;
`endif

endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

Reset sequencer on the control side of the PLL's `rst`/`locked` interface, clocked by the same 50 MHz reference that feeds the PLL. It holds the PLL in reset for a fixed interval, then waits for `locked`. Lock must stay stable for a settle interval before the core reset is released. On lock loss, lock timeout or an explicit restart request, it re-reset the PLL and re-holds the core in reset.

## Interface
- `RST_CYCLES`, default 16: refclk cycles `pll_rst` is held high per attempt; minimum 1.
- `LOCK_TIMEOUT`, default 1000000: refclk cycles to wait for lock before retrying (20 ms at 50 MHz).
- `SETTLE_CYCLES`, default 1024: consecutive synchronized-lock cycles required before release; minimum 1.
- `refclk` in 1: 50 MHz reference clock; the same net that drives the PLL `refclk`.
- `rst` in 1: asynchronous, active-high reset.
- `pll_locked` in 1: PLL `locked` output; asynchronous to `refclk`.
- `restart_req` in 1: level; while high, forces and holds the sequence in PLL_RST.
- `pll_rst` out 1: drives PLL `rst`.
- `sys_reset` out 1: active-high core reset. Downstream blocks resynchronize it into each PLL output domain.
- `ready` out 1: high only in RUN.
- `retry_cnt` out 4: saturating count of lock timeouts since `rst`.
- `lock_lost` out 1: sticky; set when lock drops in RUN; cleared only by `rst`.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `lock_s`. Both flops reset to 0.
- There is one down-counter `cnt`. Its width is $clog2 of the largest of the three parameters, plus 1.
- The FSM has four states: PLL_RST, WAIT_LOCK, SETTLE, RUN. The encoding is free.
- **PLL_RST:** `pll_rst`=1, `sys_reset`=1.
  - `cnt` counts RST_CYCLES cycles, then the FSM moves to WAIT_LOCK.
  - `restart_req` high reloads `cnt` every cycle, so this state is extended.
- **WAIT_LOCK:** `pll_rst`=0, `sys_reset`=1.
  - `lock_s`=1 moves to SETTLE and loads SETTLE_CYCLES.
  - After LOCK_TIMEOUT cycles with no lock, the FSM moves to PLL_RST and `retry_cnt` increments, saturating at 15.
- **SETTLE:** `pll_rst`=0, `sys_reset`=1.
  - `lock_s`=0 returns to WAIT_LOCK with the timeout reloaded. This is not counted as a retry.
  - After SETTLE_CYCLES consecutive cycles with `lock_s`=1, the FSM moves to RUN.
- **RUN:** `pll_rst`=0, `sys_reset`=0, `ready`=1.
  - `lock_s`=0 moves to PLL_RST and sets `lock_lost`.
- `restart_req` high in any state moves to PLL_RST on the next edge. It does not change `retry_cnt` or `lock_lost`.
- Priority on the same cycle, highest first: `restart_req`, then lock loss or timeout, then normal progress. If restart and lock loss coincide in RUN, `lock_lost` is not set.
- All outputs are registered and decoded from the next state, so each output changes on the same edge as the state change.

## Timing
- **Reset values:** state PLL_RST, `cnt`=RST_CYCLES, `pll_rst`=1, `sys_reset`=1, `ready`=0, `retry_cnt`=0, `lock_lost`=0.
- **PLL reset width:** `pll_rst` stays high for exactly RST_CYCLES rising edges after `rst` deasserts, with `restart_req` low.
- **Lock latency:** from `pll_locked` rising to the first SETTLE cycle is 3 edges (2 synchronizer edges plus 1 FSM edge).
- **Release:** `sys_reset` falls and `ready` rises on the same edge, SETTLE_CYCLES edges after SETTLE is entered.
- **Loss response:** from `pll_locked` falling in RUN, `sys_reset`=1, `ready`=0 and `pll_rst`=1 follow 3 edges later.
- **Timeout retry:** back-to-back timeouts are spaced RST_CYCLES+LOCK_TIMEOUT edges apart.
- **Mid-operation reset:** `rst` asserted mid-sequence forces all reset values immediately, asynchronously.

## Configuration
- `PLL_LOCK_TIMEOUT_EN` defined: WAIT_LOCK timeout and `retry_cnt` behave as described above.
- Not defined:
  - WAIT_LOCK waits indefinitely.
  - `retry_cnt` is tied to 0.
  - LOCK_TIMEOUT is ignored and no longer sizes `cnt`.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=50, SETTLE_CYCLES=8, with `PLL_LOCK_TIMEOUT_EN` defined.
- **Clean lock:** release `rst`, then raise `pll_locked` at edge 10 → `pll_rst` is high for edges 1–4, `sys_reset` falls at edge 21, `ready`=1.
- **Lock glitch in SETTLE:** drop `pll_locked` for 1 cycle at settle count 5 → return to WAIT_LOCK, settle restarts, release is delayed by ≥8 cycles, `retry_cnt`=0.
- **No lock:** hold `pll_locked`=0 → `pll_rst` re-pulses every 54 cycles, `retry_cnt` reaches 15 and stays at 15. Repeat without the macro → no re-pulse, `retry_cnt`=0.
- **Loss in RUN:** drop `pll_locked` → 3 edges later `sys_reset`=1 and `pll_rst`=1, `lock_lost`=1 and stays 1 after the relock completes.
- **Restart vs loss:** raise `restart_req` for 6 cycles in RUN, coincident with `pll_locked` falling → `pll_rst` is high for 6+4 cycles, `lock_lost`=0.
- **Async reset mid-SETTLE:** assert `rst` between edges → all outputs show reset values before the next edge.
